// File: rtl/button_cmd_sched_if.sv
// Command bus between the push-button front end and the LED datapath.
// master drives buttons and cmd_ready; slave (the scheduler) returns
// one-hot commands with a valid/ready handshake.
interface button_cmd_sched_if;
  logic [3:0] button;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [3:0] cmd;

  modport master (
    output button,
    output cmd_ready,
    input  cmd_valid,
    input  cmd
  );

  modport slave (
    input  button,
    input  cmd_ready,
    output cmd_valid,
    output cmd
  );
endinterface

// File: rtl/button_cmd_sched.sv
// button_cmd_sched: synchronises and debounces four push-buttons, merges
// their presses with a periodic step-right tick into per-bit pending flags,
// and issues them one at a time as one-hot commands over valid/ready.
// Fixed priority: bit0 > bit3 > bit2 > bit1.
// Optional macro AUTO_REPEAT_EN: a held button re-issues its command after
// REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
module button_cmd_sched #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_PERIOD     = 256,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic               clk,
  input  logic               rst,
  button_cmd_sched_if.slave  bus
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    rise;
  logic [3:0]    rep_fire;
  logic [3:0]    set_vec;
  logic [3:0]    pending;
  logic [3:0]    sel;
  logic [TW-1:0] tick;
  logic          tick_wrap;
  state_t        state;
  logic [3:0]    cmd_reg;
  logic          valid_reg;

  // Two-flop synchroniser on every raw button line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.button;
      sync2 <= sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      logic [DW-1:0] db_cnt;
      logic          level;
      logic          level_d;

      // Debounce: flip the level after DEBOUNCE_CYCLES consecutive differing samples
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          db_cnt  <= '0;
          level   <= 1'b0;
          level_d <= 1'b0;
        end else begin
          level_d <= level;
          if (sync2[gi] != level) begin
            if (db_cnt == DB_LAST) begin
              level  <= ~level;
              db_cnt <= '0;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end else begin
            db_cnt <= '0;
          end
        end
      end

      // Only a debounced press counts; releases are ignored
      assign rise[gi] = level & ~level_d;

`ifdef AUTO_REPEAT_EN
      localparam int RW = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          ((REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1) :
                          ((REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1);
      localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
      localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

      logic [RW-1:0] rep_cnt;
      logic          rep_first;

      // Held for long enough: first repeat after the delay, then periodic
      assign rep_fire[gi] = level & level_d &
                            (rep_first ? (rep_cnt == RD_LAST) : (rep_cnt == RP_LAST));

      // Repeat timer restarts on every press and is parked while released
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rep_cnt   <= '0;
          rep_first <= 1'b1;
        end else if (!level || !level_d) begin
          rep_cnt   <= '0;
          rep_first <= 1'b1;
        end else if (rep_fire[gi]) begin
          rep_cnt   <= '0;
          rep_first <= 1'b0;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end
`else
      assign rep_fire[gi] = 1'b0;
`endif
    end
  endgenerate

  // Free-running step tick; each wrap requests an automatic step-right
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= '0;
    end else if (tick == TICK_LAST) begin
      tick <= '0;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  assign tick_wrap = (tick == TICK_LAST);

  // A tick wrap and a bit0 press in the same cycle merge into one request
  assign set_vec = rise | rep_fire | {3'b000, tick_wrap};

  // Fixed-priority pick of the next pending command
  always_comb begin
    sel = 4'b0000;
    if (pending[0])      sel = 4'b0001;
    else if (pending[3]) sel = 4'b1000;
    else if (pending[2]) sel = 4'b0100;
    else if (pending[1]) sel = 4'b0010;
  end

  // Scheduler FSM with pending flags and registered command outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      cmd_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      case (state)
        // GAP already spent its one empty cycle, so it may issue directly
        IDLE, GAP: begin
          if (|pending) begin
            pending   <= (pending & ~sel) | set_vec;
            cmd_reg   <= sel;
            valid_reg <= 1'b1;
            state     <= ISSUE;
          end else begin
            pending   <= pending | set_vec;
            cmd_reg   <= '0;
            valid_reg <= 1'b0;
            state     <= IDLE;
          end
        end
        ISSUE: begin
          pending <= pending | set_vec;
          if (bus.cmd_ready) begin
            cmd_reg   <= '0;
            valid_reg <= 1'b0;
            state     <= GAP;
          end
        end
        default: begin
          cmd_reg   <= '0;
          valid_reg <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_valid = valid_reg;
  assign bus.cmd       = cmd_reg;

endmodule

// File: tb/tb_button_cmd_sched.sv
// Directed testbench for button_cmd_sched with default parameters.
// Cycle index i counts rising edges after the stimulus is applied
// (stimulus is applied 1 time unit after an edge, sampling likewise).
module tb_button_cmd_sched;

`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  button_cmd_sched_if bus_if ();

  button_cmd_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic do_reset(input logic [3:0] btn, input logic rdy);
    rst = 1'b1;
    bus_if.button    = btn;
    bus_if.cmd_ready = rdy;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.button    = 4'b1111;
    bus_if.cmd_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus_if.cmd_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_valid cycle %0d: got %b expected 0", i, bus_if.cmd_valid);
      end
      total++;
      if (bus_if.cmd !== 4'b0000) begin
        bad++;
        $display("FAIL reset_cmd cycle %0d: got %b expected 0000", i, bus_if.cmd);
      end
    end
    bus_if.button = 4'b0000;
    rst = 1'b0;
  endtask

  task automatic test_single_press();
    logic       ev;
    logic [3:0] ec;
    do_reset(4'b0000, 1'b1);
    bus_if.button = 4'b0001;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      ev = (i == 20);
      ec = ev ? 4'b0001 : 4'b0000;
      total++;
      if ({bus_if.cmd_valid, bus_if.cmd} !== {ev, ec}) begin
        bad++;
        $display("FAIL single_press cycle %0d: got valid=%b cmd=%b expected valid=%b cmd=%b",
                 i, bus_if.cmd_valid, bus_if.cmd, ev, ec);
      end
    end
    bus_if.button = 4'b0000;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      total++;
      if ({bus_if.cmd_valid, bus_if.cmd} !== 5'b0) begin
        bad++;
        $display("FAIL release_silent cycle %0d: got valid=%b cmd=%b expected valid=0 cmd=0000",
                 i, bus_if.cmd_valid, bus_if.cmd);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset(4'b0000, 1'b1);
    bus_if.button = 4'b0100;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (i == 10) bus_if.button = 4'b0000;
      total++;
      if ({bus_if.cmd_valid, bus_if.cmd} !== 5'b0) begin
        bad++;
        $display("FAIL glitch cycle %0d: got valid=%b cmd=%b expected valid=0 cmd=0000",
                 i, bus_if.cmd_valid, bus_if.cmd);
      end
    end
  endtask

  task automatic test_two_buttons();
    logic       ev;
    logic [3:0] ec;
    do_reset(4'b0000, 1'b1);
    bus_if.button = 4'b1010;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      ev = (i == 20) || (i == 22);
      ec = (i == 20) ? 4'b1000 : ((i == 22) ? 4'b0010 : 4'b0000);
      total++;
      if ({bus_if.cmd_valid, bus_if.cmd} !== {ev, ec}) begin
        bad++;
        $display("FAIL two_buttons cycle %0d: got valid=%b cmd=%b expected valid=%b cmd=%b",
                 i, bus_if.cmd_valid, bus_if.cmd, ev, ec);
      end
    end
    bus_if.button = 4'b0000;
  endtask

  task automatic test_backpressure();
    logic       ev;
    logic [3:0] ec;
    do_reset(4'b0000, 1'b0);
    bus_if.button = 4'b0001;
    for (int i = 1; i <= 70; i++) begin
      @(posedge clk); #1;
      ev = (i >= 20);
      ec = ev ? 4'b0001 : 4'b0000;
      total++;
      if ({bus_if.cmd_valid, bus_if.cmd} !== {ev, ec}) begin
        bad++;
        $display("FAIL backpressure_hold cycle %0d: got valid=%b cmd=%b expected valid=%b cmd=%b",
                 i, bus_if.cmd_valid, bus_if.cmd, ev, ec);
      end
    end
    bus_if.cmd_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      total++;
      if ({bus_if.cmd_valid, bus_if.cmd} !== 5'b0) begin
        bad++;
        $display("FAIL backpressure_after cycle %0d: got valid=%b cmd=%b expected valid=0 cmd=0000",
                 i, bus_if.cmd_valid, bus_if.cmd);
      end
    end
    bus_if.button = 4'b0000;
  endtask

  task automatic test_held_through_reset();
    logic       ev;
    logic [3:0] ec;
    do_reset(4'b0001, 1'b1);
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      ev = (i == 20);
      ec = ev ? 4'b0001 : 4'b0000;
      total++;
      if ({bus_if.cmd_valid, bus_if.cmd} !== {ev, ec}) begin
        bad++;
        $display("FAIL held_reset cycle %0d: got valid=%b cmd=%b expected valid=%b cmd=%b",
                 i, bus_if.cmd_valid, bus_if.cmd, ev, ec);
      end
    end
    bus_if.button = 4'b0000;
  endtask

  task automatic test_tick();
    logic       ev;
    logic [3:0] ec;
    do_reset(4'b0000, 1'b1);
    for (int i = 1; i <= 769; i++) begin
      @(posedge clk); #1;
      ev = (i == 257) || (i == 513) || (i >= 769);
      ec = ev ? 4'b0001 : 4'b0000;
      total++;
      if ({bus_if.cmd_valid, bus_if.cmd} !== {ev, ec}) begin
        bad++;
        $display("FAIL tick cycle %0d: got valid=%b cmd=%b expected valid=%b cmd=%b",
                 i, bus_if.cmd_valid, bus_if.cmd, ev, ec);
      end
      if (i == 600) bus_if.cmd_ready = 1'b0;
    end
    // Reset in the middle of an outstanding command
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus_if.cmd_valid, bus_if.cmd} !== 5'b0) begin
      bad++;
      $display("FAIL async_reset_drop: got valid=%b cmd=%b expected valid=0 cmd=0000",
               bus_if.cmd_valid, bus_if.cmd);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus_if.cmd_ready = 1'b1;
    for (int i = 1; i <= 260; i++) begin
      @(posedge clk); #1;
      ev = (i == 257);
      ec = ev ? 4'b0001 : 4'b0000;
      total++;
      if ({bus_if.cmd_valid, bus_if.cmd} !== {ev, ec}) begin
        bad++;
        $display("FAIL tick_after_reset cycle %0d: got valid=%b cmd=%b expected valid=%b cmd=%b",
                 i, bus_if.cmd_valid, bus_if.cmd, ev, ec);
      end
    end
  endtask

  task automatic test_hold();
    logic       ev;
    logic [3:0] ec;
    do_reset(4'b0000, 1'b1);
    bus_if.button = 4'b1000;
    for (int i = 1; i <= 240; i++) begin
      @(posedge clk); #1;
      ev = (i == 20) || (AR && (i >= 84) && (i <= 212) && (((i - 84) % 16) == 0));
      ec = ev ? 4'b1000 : 4'b0000;
      total++;
      if ({bus_if.cmd_valid, bus_if.cmd} !== {ev, ec}) begin
        bad++;
        $display("FAIL hold cycle %0d: got valid=%b cmd=%b expected valid=%b cmd=%b",
                 i, bus_if.cmd_valid, bus_if.cmd, ev, ec);
      end
      if (i == 200) bus_if.button = 4'b0000;
    end
  endtask

  initial begin
    bus_if.button    = 4'b0000;
    bus_if.cmd_ready = 1'b1;
    test_reset();
    test_single_press();
    test_glitch();
    test_two_buttons();
    test_backpressure();
    test_held_through_reset();
    test_hold();
    test_tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
